tt_um_rr_path_sched: RTL

Round-robin scheduler that shares one kept double-inverter output path among four external requesters on a Tiny Tapeout tile. Each requester raises a request pin, receives an exclusive time slot of programmable length on the shared path, and gets a one-cycle completion pulse. The block is the tile top and drives every output pin.

---
 rtl/tt_sched_pkg.sv | 31 +++
 rtl/tt_sync.sv | 27 ++
 rtl/tt_um_rr_path_sched.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/tt_sched_pkg.sv
// Shared types and pin-field positions for the round-robin path scheduler.
// Imported by the synchronizer and the tile top.
package tt_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   localparam int N_REQ = 4;

   localparam int REQ_LSB  = 0;
   localparam int HOLD_LSB = 4;
   localparam int DATA_LSB = 0;

   localparam int PATH_BIT = 4;
   localparam int BUSY_BIT = 5;
   localparam int IDX_LSB  = 6;
   localparam int DONE_LSB = 4;

   localparam logic [7:0] UIO_OE_VAL = 8'hF0;

   function automatic logic [N_REQ-1:0] onehot(input logic [1:0] i);
      logic [N_REQ-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/tt_sync.sv
// Multi-flop input synchronizer, async active-low reset.
// D stages deep, W bits wide; q is the last stage.
module tt_sync
   import tt_sched_pkg::*;
#(
   parameter int W = 8,
   parameter int D = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [D-1:0][W-1:0] chain;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[D-2:0], d};
      end
   end

   assign q = chain[D-1];

endmodule

// File: rtl/tt_um_rr_path_sched.sv
// Tile top: round-robin scheduler sharing one kept inverter-pair path
// among four requesters with programmable slot length.
module tt_um_rr_path_sched
   import tt_sched_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int HOLD_W      = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [N_REQ-1:0] req_s;
   logic [N_REQ-1:0] data_s;

   tt_sync #(
      .W (2 * N_REQ),
      .D (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({uio_in[DATA_LSB +: N_REQ],
               ui_in[REQ_LSB +: N_REQ]}),
      .q     ({data_s, req_s})
   );

   logic unused;
   assign unused = &{1'b0, ena, uio_in[7:4]};

   // First set bit at or after p, wrapping; bit 2 flags a hit.
   function automatic logic [2:0] rr_pick(
      input logic [N_REQ-1:0] r,
      input logic [1:0]       p
   );
      logic [1:0] j;
      logic [2:0] res;
      res = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         j = p + 2'(k);
         if (r[j]) res = {1'b1, j};
      end
      return res;
   endfunction

   state_t            state, state_n;
   logic [1:0]        ptr, ptr_n;
   logic [1:0]        idx, idx_n;
   logic [HOLD_W-1:0] cnt, cnt_n;
   logic [2:0]        pick;

   logic [N_REQ-1:0]  grant_q, grant_n;
   logic [N_REQ-1:0]  done_q, done_n;
   logic [1:0]        gidx_q, gidx_n;
   logic              busy_q, busy_n;
   logic              path_q, path_n;

   (* keep *) logic inv_a;
   (* keep *) logic inv_b;

   assign pick = rr_pick(req_s, ptr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= '0;
         idx     <= '0;
         cnt     <= '0;
         grant_q <= '0;
         done_q  <= '0;
         gidx_q  <= '0;
         busy_q  <= 1'b0;
         path_q  <= 1'b0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         idx     <= idx_n;
         cnt     <= cnt_n;
         grant_q <= grant_n;
         done_q  <= done_n;
         gidx_q  <= gidx_n;
         busy_q  <= busy_n;
         path_q  <= path_n;
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      idx_n   = idx;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (pick[2]) begin
               idx_n   = pick[1:0];
               cnt_n   = ui_in[HOLD_LSB +: HOLD_W];
               state_n = GRANT;
            end
         end
         GRANT: begin
            if (!req_s[idx] || cnt == '0) begin
               state_n = GAP;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         GAP: begin
            ptr_n   = idx + 2'd1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // The shared path: data of the upcoming grantee through two inverters.
   assign inv_a = ~data_s[idx_n];
   assign inv_b = ~inv_a;

   // Outputs register the upcoming state so they align with it.
   always_comb begin
      grant_n = '0;
      done_n  = '0;
      gidx_n  = '0;
      path_n  = 1'b0;
      busy_n  = (state_n != IDLE);
      unique case (1'b1)
         (state_n == GRANT): begin
            grant_n = onehot(idx_n);
            gidx_n  = idx_n;
            path_n  = inv_b;
         end
         (state_n == GAP): begin
            done_n = onehot(idx_n);
         end
         default: ;
      endcase
   end

   always_comb begin
      uo_out = '0;
      uo_out[N_REQ-1:0]     = grant_q;
      uo_out[PATH_BIT]      = path_q;
      uo_out[BUSY_BIT]      = busy_q;
      uo_out[IDX_LSB +: 2]  = gidx_q;
      uio_out = '0;
      uio_out[DONE_LSB +: N_REQ] = done_q;
   end

   assign uio_oe = UIO_OE_VAL;

endmodule
